turfio_command_decoder: RTL and testbench

TURFIO_COMMAND_DECODER -- requirements
Module: turfio_command_decoder

---
 rtl/turfio_cmd_pkg.sv | 33 +++
 rtl/turfio_cmd_msg_fifo.sv | 79 +++++++
 rtl/turfio_command_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_turfio_command_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/turfio_cmd_pkg.sv
// Shared definitions for the TURFIO command decoder: command word field
// positions, run-command codes and the message frame state.
package turfio_cmd_pkg;

    // Command word field layout
    localparam int unsigned TRIG_TIME_LSB  = 0;
    localparam int unsigned TRIG_TIME_W    = 15;
    localparam int unsigned TRIG_VALID_BIT = 15;
    localparam int unsigned RUN_LSB        = 16;
    localparam int unsigned RUN_W          = 2;
    localparam int unsigned MSG_BYTE_LSB   = 18;
    localparam int unsigned MSG_BYTE_W     = 8;
    localparam int unsigned MSG_VALID_BIT  = 26;
    localparam int unsigned MSG_LAST_BIT   = 27;
    localparam int unsigned RSVD_LSB       = 28;
    localparam int unsigned RSVD_W         = 4;

    // Message FIFO entry: {last, byte}
    localparam int unsigned MSG_ENTRY_W    = MSG_BYTE_W + 1;

    typedef enum logic [1:0] {
        RUN_NONE  = 2'd0,
        RUN_SYNC  = 2'd1,
        RUN_RESET = 2'd2,
        RUN_STOP  = 2'd3
    } run_cmd_e;

    typedef enum logic {
        FRAME_IDLE = 1'b0,
        FRAME_OPEN = 1'b1
    } frame_state_e;

endpackage

// File: rtl/turfio_cmd_msg_fifo.sv
// Message byte FIFO with a registered head entry. A push into a full FIFO
// is only accepted when a pop happens in the same cycle.
module turfio_cmd_msg_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   push_i,
    input  logic [turfio_cmd_pkg::MSG_ENTRY_W-1:0] push_data_i,
    input  logic                                   pop_i,
    output logic [turfio_cmd_pkg::MSG_ENTRY_W-1:0] head_o,
    output logic                                   empty_o,
    output logic                                   full_o
);
    import turfio_cmd_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [MSG_ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [MSG_ENTRY_W-1:0] head_q, head_d;
    logic                   pop, push_acc;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == FULL_CNT);
    assign pop      = pop_i && !empty_o;
    assign push_acc = push_i && (!full_o || pop);
    assign head_o   = head_q;

    // Pointer/occupancy next state; the head is taken from the incoming word
    // when the new read pointer lands on the slot being written this cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push_acc && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array, no reset needed: occupancy decides validity.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/turfio_command_decoder.sv
// TURFIO command decoder: splits each parallel command word into trigger,
// run-command and message-byte actions, frames message bytes into an
// AXI-Stream-like FIFO and tracks sticky error conditions.
module turfio_command_decoder #(
    parameter int unsigned MSG_FIFO_DEPTH = 4,
    parameter int unsigned MSG_TIMEOUT    = 255
) (
    input  logic        aclk_i,
    input  logic        aclk_rstn_i,
    input  logic [31:0] command_i,
    input  logic        command_valid_i,
    output logic        trig_o,
    output logic [14:0] trig_time_o,
    output logic [15:0] trig_count_o,
    output logic        run_sync_o,
    output logic        run_reset_o,
    output logic        run_stop_o,
    output logic [7:0]  m_msg_tdata,
    output logic        m_msg_tlast,
    output logic        m_msg_tvalid,
    input  logic        m_msg_tready,
    input  logic        err_clr_i,
    output logic        msg_overflow_o,
    output logic        frame_timeout_o,
    output logic [7:0]  rsvd_err_count_o
);
    import turfio_cmd_pkg::*;

    localparam logic [7:0] TMO_INIT = MSG_TIMEOUT[7:0];

    // Reset synchronizer: asserts asynchronously, releases after two edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Field extraction
    logic                   rsvd_hit, word_ok;
    logic                   trig_valid, msg_valid, msg_last;
    logic [TRIG_TIME_W-1:0] trig_time;
    logic [MSG_BYTE_W-1:0]  msg_byte;
    run_cmd_e               run_cmd;

    // Frame FSM
    frame_state_e state_q, state_d;
    logic [7:0]   tmo_q, tmo_d;
    logic         term_push, tmo_event;

    // FIFO interface
    logic                   fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_ovf;
    logic [MSG_ENTRY_W-1:0] fifo_wdata, fifo_head;

    // Output registers
    logic        trig_q, trig_d;
    logic [14:0] trig_time_q, trig_time_d;
    logic [15:0] trig_count_q, trig_count_d;
    logic        run_sync_q, run_sync_d;
    logic        run_reset_q, run_reset_d;
    logic        run_stop_q, run_stop_d;
    logic        ovf_q, ovf_d;
    logic        tmo_err_q, tmo_err_d;
    logic [7:0]  rsvd_cnt_q, rsvd_cnt_d;

    // Synchronize reset release to aclk_i.
    always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
        if (!aclk_rstn_i) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    assign rsvd_hit   = command_valid_i && (command_i[RSVD_LSB +: RSVD_W] != '0);
    assign word_ok    = command_valid_i && (command_i[RSVD_LSB +: RSVD_W] == '0);
    assign trig_valid = command_i[TRIG_VALID_BIT];
    assign trig_time  = command_i[TRIG_TIME_LSB +: TRIG_TIME_W];
    assign run_cmd    = run_cmd_e'(command_i[RUN_LSB +: RUN_W]);
    assign msg_byte   = command_i[MSG_BYTE_LSB +: MSG_BYTE_W];
    assign msg_valid  = command_i[MSG_VALID_BIT];
    assign msg_last   = command_i[MSG_LAST_BIT];

    // Frame FSM next state: open on a non-last byte, close on a last byte,
    // abort after MSG_TIMEOUT accepted words carrying no byte.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        term_push = 1'b0;
        tmo_event = 1'b0;
        if (word_ok) begin
            case (state_q)
                FRAME_IDLE: begin
                    if (msg_valid && !msg_last) begin
                        state_d = FRAME_OPEN;
                        tmo_d   = TMO_INIT;
                    end
                end
                FRAME_OPEN: begin
                    if (msg_valid) begin
                        tmo_d = TMO_INIT;
                        if (msg_last) begin
                            state_d = FRAME_IDLE;
                        end
                    end else if (tmo_q == 8'd1) begin
                        state_d   = FRAME_IDLE;
                        tmo_d     = TMO_INIT;
                        term_push = 1'b1;
                        tmo_event = 1'b1;
                    end else begin
                        tmo_d = tmo_q - 8'd1;
                    end
                end
                default: state_d = FRAME_IDLE;
            endcase
        end
    end

    // Frame state and timeout counter registers.
    always_ff @(posedge aclk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FRAME_IDLE;
            tmo_q   <= TMO_INIT;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    assign fifo_push  = (word_ok && msg_valid) || term_push;
    assign fifo_wdata = term_push ? {1'b1, 8'h00} : {msg_last, msg_byte};
    assign fifo_pop   = !fifo_empty && m_msg_tready;
    assign fifo_ovf   = fifo_push && fifo_full && !fifo_pop;

    turfio_cmd_msg_fifo #(
        .DEPTH (MSG_FIFO_DEPTH)
    ) u_msg_fifo (
        .clk_i       (aclk_i),
        .rst_ni      (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign m_msg_tvalid = !fifo_empty;
    assign m_msg_tlast  = fifo_head[MSG_BYTE_W];
    assign m_msg_tdata  = fifo_head[MSG_BYTE_W-1:0];

    // Trigger/run strobes and error bookkeeping; error events beat err_clr_i.
    always_comb begin
        trig_d       = 1'b0;
        trig_time_d  = trig_time_q;
        trig_count_d = trig_count_q;
        run_sync_d   = 1'b0;
        run_reset_d  = 1'b0;
        run_stop_d   = 1'b0;
        if (word_ok) begin
            if (trig_valid) begin
                trig_d       = 1'b1;
                trig_time_d  = trig_time;
                trig_count_d = trig_count_q + 16'd1;
            end
            case (run_cmd)
                RUN_SYNC:  run_sync_d  = 1'b1;
                RUN_RESET: run_reset_d = 1'b1;
                RUN_STOP:  run_stop_d  = 1'b1;
                default:   ;
            endcase
        end
        if (fifo_ovf) begin
            ovf_d = 1'b1;
        end else if (err_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (tmo_event) begin
            tmo_err_d = 1'b1;
        end else if (err_clr_i) begin
            tmo_err_d = 1'b0;
        end else begin
            tmo_err_d = tmo_err_q;
        end
        if (rsvd_hit) begin
            rsvd_cnt_d = (rsvd_cnt_q == 8'hFF) ? rsvd_cnt_q : rsvd_cnt_q + 8'd1;
        end else if (err_clr_i) begin
            rsvd_cnt_d = '0;
        end else begin
            rsvd_cnt_d = rsvd_cnt_q;
        end
    end

    // Output and error registers.
    always_ff @(posedge aclk_i or negedge rst_n) begin
        if (!rst_n) begin
            trig_q       <= 1'b0;
            trig_time_q  <= '0;
            trig_count_q <= '0;
            run_sync_q   <= 1'b0;
            run_reset_q  <= 1'b0;
            run_stop_q   <= 1'b0;
            ovf_q        <= 1'b0;
            tmo_err_q    <= 1'b0;
            rsvd_cnt_q   <= '0;
        end else begin
            trig_q       <= trig_d;
            trig_time_q  <= trig_time_d;
            trig_count_q <= trig_count_d;
            run_sync_q   <= run_sync_d;
            run_reset_q  <= run_reset_d;
            run_stop_q   <= run_stop_d;
            ovf_q        <= ovf_d;
            tmo_err_q    <= tmo_err_d;
            rsvd_cnt_q   <= rsvd_cnt_d;
        end
    end

    assign trig_o           = trig_q;
    assign trig_time_o      = trig_time_q;
    assign trig_count_o     = trig_count_q;
    assign run_sync_o       = run_sync_q;
    assign run_reset_o      = run_reset_q;
    assign run_stop_o       = run_stop_q;
    assign msg_overflow_o   = ovf_q;
    assign frame_timeout_o  = tmo_err_q;
    assign rsvd_err_count_o = rsvd_cnt_q;

endmodule

// File: tb/tb_turfio_command_decoder.sv
// Self-checking bench for turfio_command_decoder: directed scenarios followed
// by random traffic, all compared against a behavioural model.
module tb_turfio_command_decoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 3;

    logic        aclk_i = 1'b0;
    logic        aclk_rstn_i = 1'b0;
    logic [31:0] command_i = '0;
    logic        command_valid_i = 1'b0;
    logic        trig_o;
    logic [14:0] trig_time_o;
    logic [15:0] trig_count_o;
    logic        run_sync_o, run_reset_o, run_stop_o;
    logic [7:0]  m_msg_tdata;
    logic        m_msg_tlast, m_msg_tvalid;
    logic        m_msg_tready = 1'b0;
    logic        err_clr_i = 1'b0;
    logic        msg_overflow_o, frame_timeout_o;
    logic [7:0]  rsvd_err_count_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Behavioural model state
    logic [8:0]  q[$];
    bit          in_frame;
    int unsigned idle_words;
    logic        trig_e, sync_e, reset_e, stop_e;
    logic [14:0] trig_time_e;
    logic [15:0] trig_cnt_e;
    logic        ovf_e, tmo_e;
    logic [7:0]  rsvd_e;

    turfio_command_decoder #(
        .MSG_FIFO_DEPTH (DEPTH),
        .MSG_TIMEOUT    (TMO)
    ) dut (
        .aclk_i           (aclk_i),
        .aclk_rstn_i      (aclk_rstn_i),
        .command_i        (command_i),
        .command_valid_i  (command_valid_i),
        .trig_o           (trig_o),
        .trig_time_o      (trig_time_o),
        .trig_count_o     (trig_count_o),
        .run_sync_o       (run_sync_o),
        .run_reset_o      (run_reset_o),
        .run_stop_o       (run_stop_o),
        .m_msg_tdata      (m_msg_tdata),
        .m_msg_tlast      (m_msg_tlast),
        .m_msg_tvalid     (m_msg_tvalid),
        .m_msg_tready     (m_msg_tready),
        .err_clr_i        (err_clr_i),
        .msg_overflow_o   (msg_overflow_o),
        .frame_timeout_o  (frame_timeout_o),
        .rsvd_err_count_o (rsvd_err_count_o)
    );

    always #5 aclk_i = ~aclk_i;

    function automatic logic [31:0] msg(input logic [7:0] b, input logic last);
        logic [31:0] w;
        w = '0;
        w[26] = 1'b1;
        w[27] = last;
        w[25:18] = b;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_frame = 0; idle_words = 0;
        trig_e = 0; sync_e = 0; reset_e = 0; stop_e = 0;
        trig_time_e = '0; trig_cnt_e = '0;
        ovf_e = 0; tmo_e = 0; rsvd_e = '0;
    endtask

    // One clock edge of the reference behaviour given the inputs at that edge.
    task automatic model_step(input logic [31:0] w, input logic v, input logic r, input logic c);
        bit pop, ovf_ev, tmo_ev, rsvd_ev, have_push;
        logic [8:0] pd;
        pop = (q.size() != 0) && r;
        trig_e = 0; sync_e = 0; reset_e = 0; stop_e = 0;
        ovf_ev = 0; tmo_ev = 0; rsvd_ev = 0; have_push = 0; pd = '0;
        if (v) begin
            if (w[31:28] != 4'd0) begin
                rsvd_ev = 1;
            end else begin
                if (w[15]) begin
                    trig_e = 1;
                    trig_time_e = w[14:0];
                    trig_cnt_e = trig_cnt_e + 16'd1;
                end
                sync_e  = (w[17:16] == 2'd1);
                reset_e = (w[17:16] == 2'd2);
                stop_e  = (w[17:16] == 2'd3);
                if (w[26]) begin
                    have_push = 1;
                    pd = {w[27], w[25:18]};
                    idle_words = 0;
                    in_frame = !w[27];
                end else if (in_frame) begin
                    idle_words++;
                    if (idle_words == TMO) begin
                        in_frame = 0;
                        idle_words = 0;
                        tmo_ev = 1;
                        have_push = 1;
                        pd = 9'h100;
                    end
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (have_push) begin
            if (q.size() == DEPTH) ovf_ev = 1;
            else q.push_back(pd);
        end
        if (ovf_ev) ovf_e = 1; else if (c) ovf_e = 0;
        if (tmo_ev) tmo_e = 1; else if (c) tmo_e = 0;
        if (rsvd_ev) begin
            if (rsvd_e != 8'hFF) rsvd_e = rsvd_e + 8'd1;
        end else if (c) begin
            rsvd_e = '0;
        end
    endtask

    task automatic check_all();
        check("trig_o", trig_o, trig_e);
        check("trig_time", trig_time_o, trig_time_e);
        check("trig_count", trig_count_o, trig_cnt_e);
        check("run_sync", run_sync_o, sync_e);
        check("run_reset", run_reset_o, reset_e);
        check("run_stop", run_stop_o, stop_e);
        check("tvalid", m_msg_tvalid, q.size() != 0);
        if (q.size() != 0) check("tlast_tdata", {m_msg_tlast, m_msg_tdata}, q[0]);
        check("overflow", msg_overflow_o, ovf_e);
        check("frame_timeout", frame_timeout_o, tmo_e);
        check("rsvd_count", rsvd_err_count_o, rsvd_e);
    endtask

    task automatic cycle(input logic [31:0] w, input logic v, input logic r, input logic c);
        command_i = w; command_valid_i = v; m_msg_tready = r; err_clr_i = c;
        @(posedge aclk_i);
        model_step(w, v, r, c);
        #1;
        check_all();
    endtask

    // Mid-cycle asynchronous reset, then release; a word offered on the
    // first edge after release must be ignored.
    task automatic do_reset();
        @(posedge aclk_i);
        #3;
        aclk_rstn_i = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge aclk_i);
        aclk_rstn_i = 1'b1;
        command_i = 32'h0000_8001; command_valid_i = 1'b1; m_msg_tready = 1'b0; err_clr_i = 1'b0;
        @(posedge aclk_i);
        #1;
        check_all();
        cycle('0, 0, 0, 0);
        cycle('0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] w;
        model_reset();
        #1;
        check_all();
        do_reset();

        // Trigger word
        cycle(32'h0000_8123, 1, 1, 0);
        cycle('0, 0, 1, 0);

        // Run reset strobe, then a reserved-bit word that must be discarded
        cycle(32'h0002_0000, 1, 1, 0);
        cycle('0, 0, 1, 0);
        cycle(32'h1000_8001, 1, 1, 0);
        cycle('0, 0, 1, 0);

        // Two-byte frame streamed straight through
        cycle(msg(8'hA5, 0), 1, 1, 0);
        cycle(msg(8'h5A, 1), 1, 1, 0);
        cycle('0, 0, 1, 0);

        // Overfill a stalled FIFO, clear, drain
        for (int i = 0; i < 5; i++) cycle(msg(8'(8'h30 + i), 1), 1, 0, 0);
        cycle('0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle('0, 0, 1, 0);

        // Full FIFO with a simultaneous pop accepts the push
        for (int i = 0; i < 4; i++) cycle(msg(8'(8'h40 + i), 1), 1, 0, 0);
        cycle(msg(8'h44, 1), 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle('0, 0, 1, 0);

        // Frame timeout emits terminator
        cycle(msg(8'h11, 0), 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(32'h0001_0000, 1, 0, 0);
        cycle('0, 0, 1, 0);
        cycle('0, 0, 1, 1);

        // Timeout while full: terminator dropped, overflow set
        cycle(msg(8'h21, 1), 1, 0, 0);
        cycle(msg(8'h22, 1), 1, 0, 0);
        cycle(msg(8'h23, 1), 1, 0, 0);
        cycle(msg(8'h24, 0), 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle('0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle('0, 0, 1, 0);

        // Reserved-count saturation; error event beats err_clr
        for (int i = 0; i < 258; i++) cycle(32'hF000_0000, 1, 1, 0);
        cycle(32'h1000_0000, 1, 1, 1);
        cycle('0, 0, 1, 1);

        // Reset mid-frame with queued bytes: no terminator afterwards
        cycle(msg(8'h01, 0), 1, 0, 0);
        cycle(msg(8'h02, 0), 1, 0, 0);
        do_reset();
        for (int i = 0; i < 5; i++) cycle('0, 1, 1, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            if ($urandom_range(7) != 0) w[31:28] = 4'd0;
            w[26] = ($urandom_range(1) == 1);
            w[27] = ($urandom_range(2) == 0);
            cycle(w, $urandom_range(4) != 0, $urandom_range(1) == 1, $urandom_range(15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
